// File: rtl/mbus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding and owner codes.
package mbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/arb_hold_ctr.sv
// Counts consecutive granted cycles of the current owner and saturates at HOLD_MAX-1.
module arb_hold_ctr #(
  parameter int HOLD_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic limit_reached
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign limit_reached = (cnt == LIMIT);

endmodule

// File: rtl/mbus_arbiter.sv
// Two-master round-robin bus arbiter with hold-time preemption.
// Define MBUS_ARB_LOCK_EN to let a locked owner ignore hold-time preemption.
module mbus_arbiter
  import mbus_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_lock,
  input  logic             m1_lock,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m0_dout,
  input  logic [WIDTH-1:0] m1_dout,
  input  logic             m0_wen,
  input  logic             m1_wen,
  output logic             m0_gnt,
  output logic             m1_gnt,
  output logic [WIDTH-1:0] m_din,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_dout,
  output logic             bus_wen,
  input  logic [WIDTH-1:0] bus_din,
  output logic [1:0]       owner
);

  arb_state_t state;
  arb_state_t next_state;
  logic       last_owner;  // 0 = m0, 1 = m1
  logic       limit_reached;
  logic       m0_locked;
  logic       m1_locked;

`ifdef MBUS_ARB_LOCK_EN
  assign m0_locked = m0_lock;
  assign m1_locked = m1_lock;
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign m0_locked   = 1'b0;
  assign m1_locked   = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) next_state = last_owner ? OWN0 : OWN1;
        else if (m0_req)      next_state = OWN0;
        else if (m1_req)      next_state = OWN1;
      end
      OWN0: begin
        if (!m0_req)                                 next_state = m1_req ? OWN1 : IDLE;
        else if (limit_reached && m1_req && !m0_locked) next_state = OWN1;
      end
      OWN1: begin
        if (!m1_req)                                 next_state = m0_req ? OWN0 : IDLE;
        else if (limit_reached && m0_req && !m1_locked) next_state = OWN0;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      owner      <= OWNER_NONE;
      last_owner <= 1'b1;
    end else begin
      state  <= next_state;
      m0_gnt <= (next_state == OWN0);
      m1_gnt <= (next_state == OWN1);
      case (next_state)
        OWN0:    begin owner <= OWNER_M0;   last_owner <= 1'b0; end
        OWN1:    begin owner <= OWNER_M1;   last_owner <= 1'b1; end
        default: owner <= OWNER_NONE;
      endcase
    end
  end

  // Counter restarts whenever ownership is about to change or the bus is idle.
  arb_hold_ctr #(
    .HOLD_MAX(HOLD_MAX)
  ) u_hold_ctr (
    .clk          (clk),
    .reset        (reset),
    .clear        ((state == IDLE) || (next_state != state)),
    .enable       (state != IDLE),
    .limit_reached(limit_reached)
  );

  always_comb begin
    bus_addr = '0;
    bus_dout = '0;
    bus_wen  = 1'b0;
    case (state)
      OWN0: begin
        bus_addr = m0_addr;
        bus_dout = m0_dout;
        bus_wen  = m0_wen && m0_req && m0_gnt;
      end
      OWN1: begin
        bus_addr = m1_addr;
        bus_dout = m1_dout;
        bus_wen  = m1_wen && m1_req && m1_gnt;
      end
      default: ;
    endcase
  end

  assign m_din = bus_din;

endmodule

// File: tb/tb_mbus_arbiter.sv
// Directed bench for mbus_arbiter (HOLD_MAX=4); lock scenario changes with MBUS_ARB_LOCK_EN.
module tb_mbus_arbiter;

  localparam int WIDTH    = 32;
  localparam int HOLD_MAX = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen;
  logic [WIDTH-1:0] m0_addr, m1_addr, m0_dout, m1_dout, bus_din;
  logic             m0_gnt, m1_gnt, bus_wen;
  logic [WIDTH-1:0] m_din, bus_addr, bus_dout;
  logic [1:0]       owner;

  int n_checks = 0;
  int n_fail   = 0;

  mbus_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_wen(m0_wen), .m1_wen(m1_wen), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m_din(m_din), .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_wen(bus_wen),
    .bus_din(bus_din), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen} = '0;
    m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0; bus_din = '0;
    tick(); tick();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_bus_wen", bus_wen, 0);
    reset = 1'b0;

    // Idle grant with one cycle latency
    tick(); tick(); tick();
    m0_req = 1'b1; m0_addr = 32'h100;
    #1;
    chk("idle_no_gnt_yet", m0_gnt, 0);
    chk("idle_bus_addr_zero", bus_addr, 0);
    tick();
    chk("idle_m0_gnt", m0_gnt, 1);
    chk("idle_m1_gnt", m1_gnt, 0);
    chk("idle_owner", owner, 2'b01);
    chk("idle_bus_addr", bus_addr, 32'h100);
    bus_din = 32'h1234_5678;
    #1;
    chk("m_din_pass", m_din, 32'h1234_5678);

    // Release to idle, then round-robin favours m1 after m0 owned
    m0_req = 1'b0;
    tick();
    chk("release_owner", owner, 2'b00);
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("rr_second_m1", owner, 2'b10);

    // Round-robin after reset: m0 first, direct handover on req drop
    do_reset();
    chk("rr_reset_idle", owner, 2'b00);
    tick();
    chk("rr_first_m0", owner, 2'b01);
    tick(); tick();
    chk("rr_m0_hold", m0_gnt, 1);
    m0_req = 1'b0;
    tick();
    chk("rr_hand_m1", m1_gnt, 1);
    chk("rr_hand_m0off", m0_gnt, 0);
    chk("rr_hand_owner", owner, 2'b10);

    // Plain preemption: m1 takes over exactly HOLD_MAX cycles after m0's grant
    m1_req = 1'b0; m0_req = 1'b0;
    do_reset();
    m0_req = 1'b1;
    tick();
    chk("pre_grant", owner, 2'b01);
    m1_req = 1'b1;
    tick(); tick(); tick();
    chk("pre_m0_cycle4", m0_gnt, 1);
    tick();
    chk("pre_m1_gnt", m1_gnt, 1);
    chk("pre_m0_off", m0_gnt, 0);

    // Saturation: lone owner keeps the bus, yields one cycle after m1 asks
    m1_req = 1'b0; m0_req = 1'b0;
    do_reset();
    m0_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_keep", owner, 2'b01);
    m1_req = 1'b1;
    tick();
    chk("sat_yield", owner, 2'b10);

    // Lock on the owner
    m1_req = 1'b0; m0_req = 1'b0;
    do_reset();
    m0_req = 1'b1; m0_lock = 1'b1;
    tick();
    m1_req = 1'b1;
    tick(); tick(); tick(); tick();
`ifdef MBUS_ARB_LOCK_EN
    chk("lock_hold_c4", owner, 2'b01);
    for (int i = 0; i < 15; i++) tick();
    chk("lock_hold_c20", owner, 2'b01);
    m0_req = 1'b0;
    tick();
    chk("lock_release", owner, 2'b10);
`else
    chk("lock_ignored", owner, 2'b10);
`endif
    m0_lock = 1'b0;

    // Write gating: only the owner's write reaches the bus
    m1_req = 1'b0; m0_req = 1'b0;
    do_reset();
    m0_req = 1'b1;
    tick();
    m0_addr = 32'h1004; m0_dout = 32'hA5A5_A5A5; m0_wen = 1'b1;
    m1_addr = 32'hDEAD; m1_dout = 32'hFFFF_0000; m1_wen = 1'b1; m1_req = 1'b1;
    #1;
    chk("wr_addr", bus_addr, 32'h1004);
    chk("wr_dout", bus_dout, 32'hA5A5_A5A5);
    chk("wr_wen", bus_wen, 1);
    m0_wen = 1'b0;
    #1;
    chk("wr_m1_blocked", bus_wen, 0);
    m0_wen = 1'b1; m0_req = 1'b0;
    #1;
    chk("wr_noreq_wen", bus_wen, 0);
    tick();
    chk("wr_hand_m1", owner, 2'b10);
    chk("wr_m1_addr", bus_addr, 32'hDEAD);
    chk("wr_m1_wen", bus_wen, 1);

    // Reset during OWN1, then m0 wins the first arbitration
    reset = 1'b1;
    tick();
    chk("midrst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("midrst_owner", owner, 2'b00);
    chk("midrst_wen", bus_wen, 0);
    reset = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("midrst_m0_first", owner, 2'b01);
    chk("midrst_m1_off", m1_gnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
